// File: rtl/conf_int_mul_seq_apx.sv
// Sequential radix-2 shift-add multiplier. It keeps only the OP_BITWIDTH most-significant
// operand bits. If CONF_INT_MUL_SEQ_APX_SAT_EN is defined, the result saturates instead of wrapping.
module conf_int_mul_seq_apx #(
  parameter int OP_BITWIDTH        = 16,
  parameter int DATA_PATH_BITWIDTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_PATH_BITWIDTH-1:0] a,
  input  logic [DATA_PATH_BITWIDTH-1:0] b,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_PATH_BITWIDTH-1:0] d,
  output logic                          busy
);

  localparam int DW    = DATA_PATH_BITWIDTH;
  localparam int LOW   = DATA_PATH_BITWIDTH - OP_BITWIDTH;
  localparam int CNT_W = (OP_BITWIDTH > 1) ? $clog2(OP_BITWIDTH) : 1;
  localparam logic [DW-1:0]    MASK = {DW{1'b1}} << LOW;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(OP_BITWIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state_q, state_d;
  logic [2*DW-1:0] acc_q, acc_d;
  logic [2*DW-1:0] mcand_q, mcand_d;
  logic [DW-1:0]   mplier_q, mplier_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DW-1:0]   d_q, d_d;
  logic [2*DW-1:0] acc_sum;
  logic [DW-1:0]   result;

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    d_d      = d_q;
    acc_sum  = acc_q + (mplier_q[0] ? mcand_q : '0);
`ifdef CONF_INT_MUL_SEQ_APX_SAT_EN
    result   = (|acc_sum[2*DW-1:DW]) ? '1 : acc_sum[DW-1:0];
`else
    result   = acc_sum[DW-1:0];
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          // The retained multiplier bits are shifted down so that bit 0 is the first bit processed.
          // The multiplicand is placed back at the weight of that bit.
          state_d  = CALC;
          acc_d    = '0;
          cnt_d    = '0;
          mcand_d  = (2*DW)'(a & MASK) << LOW;
          mplier_d = (b & MASK) >> LOW;
        end
      end
      CALC: begin
        acc_d    = acc_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == LAST) begin
          state_d = DONE;
          d_d     = result;
          cnt_d   = '0;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      d_q      <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      d_q      <= d_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == CALC);
  assign d         = d_q;

endmodule

// File: tb/tb_conf_int_mul_seq_apx.sv
// Self-checking bench for conf_int_mul_seq_apx: the default instance plus an OP_BITWIDTH=8 instance.
module tb_conf_int_mul_seq_apx;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0, out_ready = 1'b0;
  logic [15:0] a = '0, b = '0;
  logic        in_ready, out_valid, busy;
  logic [15:0] d;
  logic        in_valid8 = 1'b0, out_ready8 = 1'b0;
  logic [15:0] a8 = '0, b8 = '0;
  logic        in_ready8, out_valid8, busy8;
  logic [15:0] d8;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  conf_int_mul_seq_apx dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .d(d), .busy(busy)
  );

  conf_int_mul_seq_apx #(.OP_BITWIDTH(8), .DATA_PATH_BITWIDTH(16)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8), .a(a8), .b(b8),
    .out_valid(out_valid8), .out_ready(out_ready8), .d(d8), .busy(busy8)
  );

  // Reference: mask the low operand bits, multiply exactly, then wrap or saturate to 16 bits.
  function automatic logic [15:0] ref_mul(input logic [15:0] x, input logic [15:0] y, input int op);
    logic [15:0] m;
    logic [31:0] p;
    m = 16'hFFFF << (16 - op);
    p = 32'(x & m) * 32'(y & m);
`ifdef CONF_INT_MUL_SEQ_APX_SAT_EN
    return (p[31:16] != 16'h0) ? 16'hFFFF : p[15:0];
`else
    return p[15:0];
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input bit use8, output int n);
    n = 0;
    while (!(use8 ? out_valid8 : out_valid) && n < 60) begin
      tick();
      n++;
    end
  endtask

  int n;
  logic [15:0] held, pa [4], pb [4], exp_q [$];
  int hs_cyc [$];
  int cyc, idx, results;
  bit hs_pending;

  initial begin
    // Reset state
    #2;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_d", d, 0);
    check("rst8_in_ready", in_ready8, 1);
    #10 rst = 1'b1;
    tick();

    // a=3, b=5 with the consumer always ready
    a = 16'd3; b = 16'd5; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    check("calc_busy", busy, 1);
    check("calc_in_ready", in_ready, 0);
    wait_valid(0, n);
    check("lat16", n, 16);
    check("d_3x5", d, 15);
    tick();
    check("idle_again", in_ready, 1);
    check("idle_ov", out_valid, 0);
    check("d_hold_idle", d, 15);

    // 0xFFFF * 2 with back-pressure; in_valid pulses must be ignored
    a = 16'hFFFF; b = 16'h0002; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    wait_valid(0, n);
    check("lat_bp", n, 16);
    check("d_ffff_x2", d, ref_mul(16'hFFFF, 16'h0002, 16));
    held = d;
    for (int k = 0; k < 5; k++) begin
      in_valid = k[0];
      a = 16'(k + 7); b = 16'(k + 9);
      tick();
      check("bp_ov", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
      check("bp_d_stable", d, held);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    check("bp_release", in_ready, 1);

    // Abort on the 7th CALC cycle
    a = 16'(16'h1234); b = 16'(16'h00FF); in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (6) tick();
    check("pre_abort_busy", busy, 1);
    rst = 1'b0;
    #1;
    check("abort_ov", out_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_d", d, 0);
    check("abort_in_ready", in_ready, 1);
    tick(); tick();
    #3 rst = 1'b1;
    n = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (out_valid) n++;
    end
    check("abort_no_result", n, 0);
    a = 16'd2; b = 16'd2; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_valid(0, n);
    check("post_abort_lat", n, 16);
    check("post_abort_d", d, 4);
    tick();

    // OP_BITWIDTH=8 instance: approximation and an 8-cycle latency
    a8 = 16'h0123; b8 = 16'h0101; in_valid8 = 1'b1; out_ready8 = 1'b1;
    tick();
    in_valid8 = 1'b0;
    wait_valid(1, n);
    check("lat8", n, 8);
    check("d8_apx", d8, ref_mul(16'h0123, 16'h0101, 8));
    tick();
    for (int k = 0; k < 3; k++) begin
      a8 = 16'($urandom_range(0, 16'hFFFF)); b8 = 16'($urandom_range(0, 16'hFFF));
      in_valid8 = 1'b1;
      tick();
      in_valid8 = 1'b0;
      wait_valid(1, n);
      check("lat8_rand", n, 8);
      check("d8_rand", d8, ref_mul(a8, b8, 8));
      tick();
    end

    // Back-to-back stream with in_valid and out_ready held high
    for (int k = 0; k < 4; k++) begin
      pa[k] = 16'($urandom_range(0, 16'hFFFF));
      pb[k] = 16'($urandom_range(0, 16'hFFFF));
    end
    pa[0] = 16'h0000;
    idx = 0; results = 0; cyc = 0;
    a = pa[0]; b = pb[0]; in_valid = 1'b1; out_ready = 1'b1;
    while (results < 4 && cyc < 200) begin
      hs_pending = in_ready && (idx < 4);
      tick();
      cyc++;
      if (hs_pending) begin
        hs_cyc.push_back(cyc);
        exp_q.push_back(ref_mul(pa[idx], pb[idx], 16));
        idx++;
        if (idx < 4) begin
          a = pa[idx]; b = pb[idx];
        end else begin
          in_valid = 1'b0;
        end
      end
      if (out_valid) begin
        if (exp_q.size() > 0) check("stream_d", d, exp_q.pop_front());
        else check("stream_extra", 1, 0);
        results++;
      end
    end
    check("stream_count", results, 4);
    check("stream_hs_count", hs_cyc.size(), 4);
    for (int k = 1; k < hs_cyc.size(); k++)
      check("stream_period", hs_cyc[k] - hs_cyc[k-1], 18);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/conf_int_mul_seq_apx.md
CONF_INT_MUL_SEQ_APX -- requirements
Module: conf_int_mul_seq_apx

Interface
REQ-001 SHALL have parameter OP_BITWIDTH, default 16, the number of effective (most-significant) operand bits used in the multiply; legal range is 1..DATA_PATH_BITWIDTH.
REQ-002 SHALL have parameter DATA_PATH_BITWIDTH, default 16, the operand and result port width.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit, asynchronous active-low reset.
REQ-005 SHALL have port in_valid, input, 1 bit, operand pair valid.
REQ-006 SHALL have port in_ready, output, 1 bit, block can accept operands.
REQ-007 SHALL have port a, input, DATA_PATH_BITWIDTH bits, multiplicand (unsigned).
REQ-008 SHALL have port b, input, DATA_PATH_BITWIDTH bits, multiplier (unsigned).
REQ-009 SHALL have port out_valid, output, 1 bit, result valid.
REQ-010 SHALL have port out_ready, input, 1 bit, consumer accepts result.
REQ-011 SHALL have port d, output, DATA_PATH_BITWIDTH bits, registered result.
REQ-012 SHALL have port busy, output, 1 bit, high in CALC state.

Function
REQ-013 SHALL implement FSM states IDLE, CALC, DONE; in_ready=1 only in IDLE, out_valid=1 only in DONE, busy=1 only in CALC.
REQ-014 Input handshake SHALL occur on a rising edge with in_valid=1 and in_ready=1; a and b are captured and the FSM enters CALC.
REQ-015 Approximation: at capture, the low (DATA_PATH_BITWIDTH-OP_BITWIDTH) bits of a and of b SHALL be forced to zero; OP_BITWIDTH=DATA_PATH_BITWIDTH gives an exact product.
REQ-016 CALC SHALL run radix-2 shift-add over the OP_BITWIDTH retained bits of b, one bit per cycle, into a 2*DATA_PATH_BITWIDTH-bit accumulator; a 0..OP_BITWIDTH-1 iteration counter is held.
REQ-017 The FSM SHALL enter DONE on the edge completing iteration OP_BITWIDTH-1; out_valid is visible exactly OP_BITWIDTH cycles after the input handshake edge.
REQ-018 d SHALL load on entry to DONE and hold its value until the next DONE entry or reset, including while out_ready=0.
REQ-019 Output handshake SHALL occur on an edge with out_valid=1 and out_ready=1; the FSM returns to IDLE.
REQ-020 There is no overlap: the next handshake is accepted no earlier than the edge after the return to IDLE, so the minimum period is OP_BITWIDTH+2 cycles.
REQ-021 in_valid, a and b SHALL be ignored outside IDLE; out_ready SHALL be ignored outside DONE.
REQ-022 Operands equal to zero SHALL still take the full OP_BITWIDTH cycles; there is no early exit.

Reset
REQ-023 rst=0 SHALL immediately force IDLE, clear the accumulator, counter and d, and drive out_valid=0, busy=0, in_ready=1, from any state including mid-CALC.
REQ-024 An aborted operation SHALL never produce out_valid; after rst rises, the first handshake behaves as from power-up.

Configuration
REQ-025 With macro CONF_INT_MUL_SEQ_APX_SAT_EN defined, d SHALL equal all-ones whenever accumulator bits [2*DATA_PATH_BITWIDTH-1:DATA_PATH_BITWIDTH] are nonzero, else the accumulator low half.
REQ-026 Without CONF_INT_MUL_SEQ_APX_SAT_EN, d SHALL equal the accumulator bits [DATA_PATH_BITWIDTH-1:0] (wrap-around), with no saturation logic present.

Verification
REQ-027 Defaults, a=3, b=5, out_ready=1 -> out_valid high 16 cycles after accept, d=15, then in_ready returns high.
REQ-028 OP_BITWIDTH=8, DW=16, a=0x0123, b=0x0101 -> masked 0x0100*0x0100=0x10000; d=0x0000 without the macro, d=0xFFFF with CONF_INT_MUL_SEQ_APX_SAT_EN.
REQ-029 Defaults, a=0xFFFF, b=0x0002, out_ready held 0 for 5 cycles after out_valid -> d=0xFFFE (no macro) stable throughout, in_ready=0, in_valid pulses ignored.
REQ-030 rst pulled low on the 7th CALC cycle -> same-cycle out_valid=0, busy=0, d=0, in_ready=1; no result emitted; next op a=2, b=2 gives d=4.
REQ-031 in_valid and out_ready held 1 with 4 operand pairs -> 4 results in order, handshakes exactly 18 cycles apart, products equal the reference model a*b masked per REQ-015.
